// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-triggered interrupt collector with round-robin arbitration
// and a REQ / acknowledge / WAIT_LOW handshake to a processor controller.
`default_nettype none

module irq_arbiter #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic            ext_irq_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic            found;
  logic [IDW-1:0]  sel;

  assign rise     = irq_in & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Walk offsets from far to near so the nearest eligible source above
  // last_grant is the one left in sel.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int off = NSRC; off >= 1; off--) begin
      idx = (int'(last_grant_q) + off) % NSRC;
      if (eligible[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    last_grant_d = last_grant_q;
    clr          = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_REQ;
          irq_id_d     = sel;
          last_grant_d = sel;
        end
      end
      S_REQ: begin
        if (ExtIAck) begin
          for (int i = 0; i < NSRC; i++) begin
            if (i == int'(irq_id_q)) clr[i] = 1'b1;
          end
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!ExtIAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh edge on the source being cleared wins over the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      irq_id_q     <= '0;
      last_grant_q <= IDW'(NSRC - 1);
      ext_irq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      irq_id_q     <= irq_id_d;
      last_grant_q <= last_grant_d;
      ext_irq_q    <= (state_d == S_REQ);
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign ExtIRQ  = ext_irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed self-checking bench for irq_arbiter.
`default_nettype none

module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ExtIAck;
  logic       ExtIRQ;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask;

  int total = 0;
  int bad   = 0;

  irq_arbiter #(.NSRC(4), .IDW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ExtIAck    (ExtIAck),
    .ExtIRQ     (ExtIRQ),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ExtIAck = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    total++; if (ExtIRQ !== 1'b0) begin bad++; $display("FAIL reset_extirq got=%b exp=0", ExtIRQ); end
    total++; if (irq_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    total++; if (mask !== 4'b0000) begin bad++; $display("FAIL reset_mask got=%b exp=0000", mask); end
    tick();
    reset = 1'b0;
  endtask

  // Single source then a 3-cycle acknowledge.
  task automatic test_single_handshake();
    do_reset();
    irq_in = 4'b0100;
    tick();
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pend got=%b exp=0100", pending); end
    total++; if (ExtIRQ !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", ExtIRQ); end
    irq_in = 4'b0000;
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin bad++; $display("FAIL single_req got=%b/%0d exp=1/2", ExtIRQ, irq_id); end
    tick(); tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin bad++; $display("FAIL single_hold got=%b/%0d exp=1/2", ExtIRQ, irq_id); end
    ExtIAck = 1'b1;
    tick();
    total++; if (pending !== 4'b0000 || ExtIRQ !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b/%b exp=0000/0", pending, ExtIRQ); end
    tick(); tick();
    total++; if (ExtIRQ !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL ack_held got=%b/%b exp=0/0000", ExtIRQ, pending); end
    ExtIAck = 1'b0;
    tick(); tick(); tick();
    total++; if (ExtIRQ !== 1'b0) begin bad++; $display("FAIL no_regrant got=%b exp=0", ExtIRQ); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      irq_in = 4'b1111;
      tick();
      total++; if (pending !== 4'b1111) begin bad++; $display("FAIL rr_pend b=%0d got=%b exp=1111", b, pending); end
      irq_in = 4'b0000;
      tick();
      for (int g = 0; g < 4; g++) begin
        total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'(g)) begin bad++; $display("FAIL rr_grant b=%0d got=%b/%0d exp=1/%0d", b, ExtIRQ, irq_id, g); end
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
        tick();
        tick();
      end
      total++; if (ExtIRQ !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL rr_done b=%0d got=%b/%b exp=0/0000", b, ExtIRQ, pending); end
    end
  endtask

  task automatic test_mask();
    do_reset();
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    total++; if (mask !== 4'b0001) begin bad++; $display("FAIL mask_load got=%b exp=0001", mask); end
    irq_in = 4'b0011;
    tick();
    irq_in = 4'b0000;
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin bad++; $display("FAIL mask_grant got=%b/%0d exp=1/1", ExtIRQ, irq_id); end
    ExtIAck = 1'b1;
    tick();
    ExtIAck = 1'b0;
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL mask_pend got=%b exp=0001", pending); end
    tick(); tick();
    total++; if (ExtIRQ !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%b exp=0", ExtIRQ); end
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin bad++; $display("FAIL unmask_grant got=%b/%0d exp=1/0", ExtIRQ, irq_id); end
    mask_we = 1'b1; mask_wdata = 4'b1111; irq_in = 4'b1000;
    tick();
    mask_we = 1'b0; irq_in = 4'b0000;
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0 || mask !== 4'b1111) begin bad++; $display("FAIL req_hold got=%b/%0d/%b exp=1/0/1111", ExtIRQ, irq_id, mask); end
  endtask

  task automatic test_collision_and_idle_ack();
    do_reset();
    ExtIAck = 1'b1;
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b0010) begin bad++; $display("FAIL idle_ack got=%b/%0d/%b exp=1/1/0010", ExtIRQ, irq_id, pending); end
    irq_in = 4'b0010;
    tick();
    total++; if (pending !== 4'b0010 || ExtIRQ !== 1'b0) begin bad++; $display("FAIL collide_pend got=%b/%b exp=0010/0", pending, ExtIRQ); end
    irq_in = 4'b0000; ExtIAck = 1'b0;
    tick();
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin bad++; $display("FAIL collide_regrant got=%b/%0d exp=1/1", ExtIRQ, irq_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_in = 4'b0110;
    tick();
    irq_in = 4'b0000;
    tick();
    total++; if (ExtIRQ !== 1'b1 || pending !== 4'b0110) begin bad++; $display("FAIL mid_setup got=%b/%b exp=1/0110", ExtIRQ, pending); end
    #2 reset = 1'b1;
    #1;
    total++; if (ExtIRQ !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL mid_async got=%b/%b exp=0/0000", ExtIRQ, pending); end
    irq_in = 4'b0001;
    tick();
    reset = 1'b0;
    tick();
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL high_at_release got=%b exp=0001", pending); end
    tick();
    total++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin bad++; $display("FAIL release_grant got=%b/%0d exp=1/0", ExtIRQ, irq_id); end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ExtIAck = 1'b0;
    test_reset();
    test_single_handshake();
    test_round_robin();
    test_mask();
    test_collision_and_idle_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter: NSRC, default 4, number of external interrupt sources (2..8).
REQ-002 Parameter: IDW, default 2, width of source id; SHALL equal ceil(log2(NSRC)).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: irq_in  input  NSRC  raw interrupt lines from peripherals, rising-edge triggered.
REQ-006 Port: mask_we  input  1  mask write strobe.
REQ-007 Port: mask_wdata  input  NSRC  new mask value; 1 = source masked.
REQ-008 Port: ExtIAck  input  1  acknowledge from the processor controller.
REQ-009 Port: ExtIRQ  output  1  interrupt request to the processor controller, registered.
REQ-010 Port: irq_id  output  IDW  index of the source being requested/serviced, registered.
REQ-011 Port: pending  output  NSRC  latched pending flags.
REQ-012 Port: mask  output  NSRC  current mask register.

Function
REQ-013 The block SHALL register irq_in each cycle (irq_prev) and detect a rising edge as irq_in[i]=1 with irq_prev[i]=0.
REQ-014 The block SHALL set pending[i] on the clock edge at which that rising edge is detected, regardless of mask[i].
REQ-015 A source SHALL be eligible when pending[i]=1 and mask[i]=0.
REQ-016 mask SHALL load mask_wdata on any edge with mask_we=1, in every FSM state.
REQ-017 The FSM SHALL have exactly three states: IDLE, REQ and WAIT_LOW.
REQ-018 IDLE: if any source is eligible, the FSM SHALL select one by round-robin, latch its index into irq_id, and go to REQ.
REQ-019 Otherwise in IDLE the FSM SHALL stay in IDLE.
REQ-020 Round-robin SHALL search upward from (last_grant+1) mod NSRC, wrapping around; last_grant SHALL update to the selected index.
REQ-021 ExtIRQ SHALL be 1 exactly while the state is REQ.
REQ-022 REQ: ExtIRQ and irq_id SHALL hold until ExtIAck=1; mask writes and new pending bits SHALL NOT change irq_id or withdraw the request.
REQ-023 REQ with ExtIAck=1: the block SHALL clear pending[irq_id] and go to WAIT_LOW.
REQ-024 WAIT_LOW: the FSM SHALL stay until ExtIAck=0, then go to IDLE; an ExtIAck held high SHALL never cause a second clear.
REQ-025 If a new rising edge on source irq_id coincides with its clear, the set SHALL win and pending stays 1.
REQ-026 ExtIAck=1 while in IDLE SHALL be ignored.
REQ-027 Latency: for a rising edge detected at clock edge k on an unmasked source with the FSM idle, ExtIRQ SHALL be 1 after edge k+1.
REQ-028 Minimum spacing between two grants SHALL be 3 cycles (REQ, WAIT_LOW, IDLE).

Reset
REQ-029 Asynchronous reset SHALL force state=IDLE, ExtIRQ=0, irq_id=0, pending=0, mask=0, irq_prev=0, last_grant=NSRC-1.
REQ-030 The reset value of last_grant SHALL give source 0 first priority after reset.
REQ-031 Reset asserted mid-REQ or mid-WAIT_LOW SHALL drop ExtIRQ immediately and discard all pending requests.
REQ-032 An irq_in line already high when reset deasserts SHALL register as a rising edge on the first clock edge after reset.

Verification
REQ-033 Single source: pulse irq_in[2] at edge 5, no ack -> pending=4'b0100 after edge 5; ExtIRQ=1 and irq_id=2 after edge 6 and held.
REQ-034 Handshake: from REQ-033, raise ExtIAck for 3 cycles -> pending=0 after the first ack edge; ExtIRQ=0; no further grant; IDLE after ExtIAck falls.
REQ-035 Round-robin: irq_in=4'b1111 pulsed simultaneously, ack each request -> grant order 0,1,2,3.
REQ-035 (cont.) Second simultaneous burst -> grant order starts at 0 again, because last_grant=3.
REQ-036 Masking: mask=4'b0001, pulse sources 0 and 1 -> only id 1 granted; pending[0] stays 1.
REQ-036 (cont.) Write mask=0 -> id 0 granted next.
REQ-037 Collision: new rising edge on the granted source at the ack edge -> pending bit stays 1 and it is granted again after WAIT_LOW.
REQ-038 Reset during REQ with pending=4'b0110 -> ExtIRQ=0 and pending=0 asynchronously, before the next clock edge.
